// File: rtl/frame_packager_pkg.sv
// Shared types and helpers for the frame packager: FSM state encoding and FIFO entry sizing.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package frame_packager_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_FLUSH   = 3'd3,
        ST_DONE    = 3'd4
    } fp_state_e;

`ifdef FRAME_PACKAGER_TUSER_EN
    localparam int TUSER_BITS = 1;
`else
    localparam int TUSER_BITS = 0;
`endif

    // One FIFO entry carries the pixel beat, the frame-tlast flag and, optionally, tuser.
    function automatic int fifo_entry_width(input int data_width);
        return data_width + 1 + TUSER_BITS;
    endfunction

endpackage

// File: rtl/frame_packager_if.sv
// Video-in / AXI-Stream-out bundle of the frame packager.
// Latency: n/a (wiring only).
// Backpressure: video_ready throttles the source, m_axis_tready throttles the packager.
// The slave modport is the packager's view; master is the surrounding environment's view.
// m_axis_tuser exists only when FRAME_PACKAGER_TUSER_EN is defined.
interface frame_packager_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] video_data;
    logic                  video_valid;
    logic                  video_ready;
    logic                  video_start_frame;
    logic                  video_tlast;
    logic [DATA_WIDTH-1:0] m_axis_tdata;
    logic                  m_axis_tvalid;
    logic                  m_axis_tlast;
    logic                  m_axis_tready;
`ifdef FRAME_PACKAGER_TUSER_EN
    logic                  m_axis_tuser;

    modport slave (
        input  video_data, video_valid, video_start_frame, video_tlast,
        output video_ready,
        output m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
        input  m_axis_tready
    );

    modport master (
        output video_data, video_valid, video_start_frame, video_tlast,
        input  video_ready,
        input  m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
        output m_axis_tready
    );
`else
    modport slave (
        input  video_data, video_valid, video_start_frame, video_tlast,
        output video_ready,
        output m_axis_tdata, m_axis_tvalid, m_axis_tlast,
        input  m_axis_tready
    );

    modport master (
        output video_data, video_valid, video_start_frame, video_tlast,
        input  video_ready,
        input  m_axis_tdata, m_axis_tvalid, m_axis_tlast,
        output m_axis_tready
    );
`endif
endinterface

// File: rtl/packager_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with a registered output stage.
// Latency: entry written at edge N appears on o_rd_* after edge N+1 when the FIFO was empty.
// Backpressure: o_full from the registered count; output holds while i_rd_rdy is low.
// Ports: i_clk/i_rst (sync, active-high); i_wr_vld/i_wr_dat write side;
//        o_rd_vld/o_rd_dat/i_rd_rdy read side; o_full/o_empty/o_count status.
module packager_sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_wr_vld,
    input  logic [WIDTH-1:0]         i_wr_dat,
    output logic                     o_rd_vld,
    output logic [WIDTH-1:0]         o_rd_dat,
    input  logic                     i_rd_rdy,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    // Total occupancy: entries in r_mem plus the one held in the output register.
    logic [CW-1:0]    r_count;
    logic             r_out_vld;
    logic [WIDTH-1:0] r_out_dat;

    logic             w_wr;
    logic             w_rd;
    logic [CW-1:0]    w_mem_cnt;
    logic             w_load;

    assign w_wr      = i_wr_vld & ~o_full;
    assign w_rd      = r_out_vld & i_rd_rdy;
    assign w_mem_cnt = r_count - CW'(r_out_vld);
    // Refill the output register whenever it is free or being consumed this cycle.
    assign w_load    = (w_mem_cnt != '0) & (~r_out_vld | w_rd);

    always_ff @(posedge i_clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_wr_dat;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_out_vld <= 1'b0;
            r_out_dat <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_load) begin
                r_out_dat <= r_mem[r_rd_ptr];
                r_rd_ptr  <= r_rd_ptr + 1'b1;
                r_out_vld <= 1'b1;
            end else if (w_rd) begin
                r_out_vld <= 1'b0;
            end
            r_count <= r_count + CW'(w_wr) - CW'(w_rd);
        end
    end

    assign o_rd_vld = r_out_vld;
    assign o_rd_dat = r_out_dat;
    assign o_full   = (r_count == CW'(DEPTH));
    assign o_empty  = (r_count == '0);
    assign o_count  = r_count;

endmodule

// File: rtl/frame_packager.sv
// Captures line_count video lines from a start-of-frame marker into an AXI-Stream frame.
// Latency: beat accepted at edge N leaves on m_axis_* after edge N+1 when the buffer is empty.
// Backpressure: m_axis_tready stalls the output; video_ready drops only while capturing with a full buffer.
// Ports: i_video_clk, i_video_reset/i_soft_reset (sync, active-high), i_enable, i_continuous,
//        i_line_count; io_bus carries video_* in and m_axis_* out; o_t_last_count, o_busy,
//        o_frame_done (one-cycle pulse), o_aborted (sticky).
// Optional: FRAME_PACKAGER_TUSER_EN adds m_axis_tuser flagging the start-of-frame beat.
module frame_packager
    import frame_packager_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int FIFO_DEPTH  = 16,
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   i_video_clk,
    input  logic                   i_video_reset,
    input  logic                   i_soft_reset,
    input  logic                   i_enable,
    input  logic                   i_continuous,
    input  logic [COUNT_WIDTH-1:0] i_line_count,
    frame_packager_if.slave        io_bus,
    output logic [COUNT_WIDTH-1:0] o_t_last_count,
    output logic                   o_busy,
    output logic                   o_frame_done,
    output logic                   o_aborted
);
    localparam int EW = fifo_entry_width(DATA_WIDTH);
    localparam int FCW = $clog2(FIFO_DEPTH) + 1;

    fp_state_e              r_state;
    fp_state_e              w_next_state;
    logic [COUNT_WIDTH-1:0] r_t_last_count;
    logic                   r_aborted;
    logic                   r_frame_done;

    logic                   w_rst;
    logic [COUNT_WIDTH-1:0] w_target;
    logic [COUNT_WIDTH-1:0] w_cnt_inc;
    logic                   w_start;
    logic                   w_start_last;
    logic                   w_cap_accept;
    logic                   w_cap_line_end;
    logic                   w_cap_last;

    logic                   w_video_ready;
    logic                   w_fifo_wr;
    logic                   w_last_bit;
    logic [EW-1:0]          w_wr_entry;
    logic [EW-1:0]          w_rd_entry;
    logic                   w_rd_vld;
    logic                   w_fifo_full;
    logic                   w_fifo_empty;
    logic [FCW-1:0]         w_fifo_count;

    assign w_rst    = i_video_reset | i_soft_reset;
    assign w_target = (i_line_count == '0) ? COUNT_WIDTH'(1) : i_line_count;
    // Saturating increment of the completed-line counter.
    assign w_cnt_inc = (r_t_last_count == '1) ? r_t_last_count
                                              : r_t_last_count + COUNT_WIDTH'(1);

    // Outside CAPTURE the source is never stalled, so the start beat needs no ready term.
    assign w_start        = (r_state == ST_ARMED) & i_enable & io_bus.video_valid
                          & io_bus.video_start_frame;
    // A one-line frame can finish on its own start beat.
    assign w_start_last   = w_start & io_bus.video_tlast & (w_target == COUNT_WIDTH'(1));
    assign w_cap_accept   = (r_state == ST_CAPTURE) & io_bus.video_valid & ~w_fifo_full;
    assign w_cap_line_end = w_cap_accept & io_bus.video_tlast;
    assign w_cap_last     = w_cap_line_end & (w_cnt_inc == w_target);

    always_ff @(posedge i_video_clk) begin
        if (w_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_enable) w_next_state = ST_ARMED;
            end
            ST_ARMED: begin
                if (!i_enable)         w_next_state = ST_IDLE;
                else if (w_start_last) w_next_state = ST_FLUSH;
                else if (w_start)      w_next_state = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (!i_enable || w_cap_last) w_next_state = ST_FLUSH;
            end
            ST_FLUSH: begin
                if (w_fifo_count == '0) begin
                    if (i_continuous && i_enable) w_next_state = ST_ARMED;
                    else if (i_enable)            w_next_state = ST_DONE;
                    else                          w_next_state = ST_IDLE;
                end
            end
            ST_DONE: begin
                if (!i_enable) w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        w_video_ready = 1'b1;
        w_fifo_wr     = 1'b0;
        w_last_bit    = 1'b0;
        case (r_state)
            ST_ARMED: begin
                w_fifo_wr  = w_start;
                w_last_bit = w_start_last;
            end
            ST_CAPTURE: begin
                w_video_ready = ~w_fifo_full;
                w_fifo_wr     = w_cap_accept;
                w_last_bit    = w_cap_last;
            end
            default: begin
                w_video_ready = 1'b1;
            end
        endcase
    end

    always_ff @(posedge i_video_clk) begin
        if (w_rst) begin
            r_t_last_count <= '0;
            r_aborted      <= 1'b0;
            r_frame_done   <= 1'b0;
        end else begin
            r_frame_done <= w_rd_vld & io_bus.m_axis_tready & w_rd_entry[DATA_WIDTH];
            if (w_start) begin
                r_t_last_count <= io_bus.video_tlast ? COUNT_WIDTH'(1) : '0;
                r_aborted      <= 1'b0;
            end else if (w_cap_line_end) begin
                r_t_last_count <= w_cnt_inc;
            end
            if ((r_state == ST_CAPTURE) && !i_enable) begin
                r_aborted <= 1'b1;
            end
        end
    end

`ifdef FRAME_PACKAGER_TUSER_EN
    assign w_wr_entry = {w_start, w_last_bit, io_bus.video_data};
    assign io_bus.m_axis_tuser = w_rd_entry[DATA_WIDTH+1];
`else
    assign w_wr_entry = {w_last_bit, io_bus.video_data};
`endif

    packager_sync_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk    (i_video_clk),
        .i_rst    (w_rst),
        .i_wr_vld (w_fifo_wr),
        .i_wr_dat (w_wr_entry),
        .o_rd_vld (w_rd_vld),
        .o_rd_dat (w_rd_entry),
        .i_rd_rdy (io_bus.m_axis_tready),
        .o_full   (w_fifo_full),
        .o_empty  (w_fifo_empty),
        .o_count  (w_fifo_count)
    );

    assign io_bus.video_ready   = w_video_ready;
    assign io_bus.m_axis_tvalid = w_rd_vld;
    assign io_bus.m_axis_tdata  = w_rd_entry[DATA_WIDTH-1:0];
    assign io_bus.m_axis_tlast  = w_rd_entry[DATA_WIDTH];

    assign o_t_last_count = r_t_last_count;
    assign o_aborted      = r_aborted;
    assign o_frame_done   = r_frame_done;
    assign o_busy         = ((r_state != ST_IDLE) && (r_state != ST_DONE)) || !w_fifo_empty;

endmodule

// File: tb/tb_frame_packager.sv
// Directed bench for frame_packager: normal frame, backpressure, continuous, abort,
// line_count of zero and reset mid-frame, each against hand-computed beat lists.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_frame_packager;
    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int CW    = 32;

    logic          clk = 1'b0;
    always #5 clk = ~clk;

    logic          video_reset;
    logic          soft_reset;
    logic          enable;
    logic          continuous;
    logic [CW-1:0] line_count;
    logic [CW-1:0] t_last_count;
    logic          busy;
    logic          frame_done;
    logic          aborted;

    frame_packager_if #(.DATA_WIDTH(DW)) bus ();

    frame_packager #(
        .DATA_WIDTH  (DW),
        .FIFO_DEPTH  (DEPTH),
        .COUNT_WIDTH (CW)
    ) dut (
        .i_video_clk    (clk),
        .i_video_reset  (video_reset),
        .i_soft_reset   (soft_reset),
        .i_enable       (enable),
        .i_continuous   (continuous),
        .i_line_count   (line_count),
        .io_bus         (bus),
        .o_t_last_count (t_last_count),
        .o_busy         (busy),
        .o_frame_done   (frame_done),
        .o_aborted      (aborted)
    );

    // Downstream ready: a fixed level, or high one cycle in three.
    int   tr_mode  = 0;
    logic tr_level = 1'b1;
    int   cyc      = 0;
    always @(posedge clk) begin
        #1;
        bus.m_axis_tready = (tr_mode != 0) ? (cyc % 3 == 0) : tr_level;
        cyc++;
    end

    // Output monitor: records every handshaken beat as {tlast, tdata}.
    logic [8:0] got[$];
    int         fd_cnt   = 0;
    int         rdy_low  = 0;
    int         stab_err = 0;
    logic       prev_stall = 1'b0;
    logic [9:0] prev_out   = '0;
    always @(negedge clk) begin
        if (bus.m_axis_tvalid === 1'b1 && bus.m_axis_tready === 1'b1)
            got.push_back({bus.m_axis_tlast, bus.m_axis_tdata});
        if (frame_done === 1'b1) fd_cnt++;
        if (bus.video_ready !== 1'b1) rdy_low++;
        if (prev_stall && ({bus.m_axis_tvalid, bus.m_axis_tlast, bus.m_axis_tdata} !== prev_out))
            stab_err++;
        prev_out   = {bus.m_axis_tvalid, bus.m_axis_tlast, bus.m_axis_tdata};
        prev_stall = !(video_reset || soft_reset) && (bus.m_axis_tvalid === 1'b1)
                     && (bus.m_axis_tready === 1'b0);
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one beat and hold it until accepted; returns 1 time unit after the accepting edge.
    task automatic send(input logic [7:0] d, input logic sof, input logic tl);
        int n;
        n = 0;
        bus.video_data        = d;
        bus.video_start_frame = sof;
        bus.video_tlast       = tl;
        bus.video_valid       = 1'b1;
        @(negedge clk);
        while (bus.video_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("send_accept_timeout", 32'(n >= 200), 0);
        @(posedge clk);
        #1;
        bus.video_valid       = 1'b0;
        bus.video_start_frame = 1'b0;
        bus.video_tlast       = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] d0, input int lines, input int bpl);
        for (int l = 0; l < lines; l++)
            for (int b = 0; b < bpl; b++)
                send(8'(d0 + l * bpl + b), (l == 0 && b == 0), (b == bpl - 1));
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (busy !== 1'b0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_drain_timeout"}, 32'(n >= 500), 0);
        @(posedge clk);
        #1;
    endtask

    // Beats from index base: data d0+i, tlast on every period-th beat (period 0: never).
    task automatic check_frame(input string name, input int base, input int n,
                               input logic [7:0] d0, input int period);
        chk({name, "_beats"}, got.size() - base, n);
        for (int i = 0; i < n; i++) begin
            if (base + i < got.size()) begin
                logic exp_last;
                exp_last = (period != 0) && ((i + 1) % period == 0);
                chk($sformatf("%s_b%0d", name, i), 32'(got[base + i]), {23'd0, exp_last, 8'(d0 + i)});
            end
        end
    endtask

    task automatic rearm();
        enable = 1'b0;
        step(2);
        enable = 1'b1;
        step(2);
    endtask

    initial begin
        int base;
        int fd0;
        int r0;
        video_reset           = 1'b0;
        soft_reset            = 1'b1;
        enable                = 1'b0;
        continuous            = 1'b0;
        line_count            = 3;
        bus.video_data        = '0;
        bus.video_valid       = 1'b0;
        bus.video_start_frame = 1'b0;
        bus.video_tlast       = 1'b0;
        step(3);
        soft_reset = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_tvalid", bus.m_axis_tvalid, 0);
        chk("rst_tlast", bus.m_axis_tlast, 0);
        chk("rst_tdata", bus.m_axis_tdata, 0);
        chk("rst_video_ready", bus.video_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_aborted", aborted, 0);
        chk("rst_tlc", t_last_count, 0);
        @(posedge clk);
        #1;

        // 1: three 4-beat lines, downstream always ready
        enable = 1'b1;
        step(2);
        base = got.size();
        fd0  = fd_cnt;
        send_frame(8'h10, 3, 4);
        wait_idle("t1");
        check_frame("t1", base, 12, 8'h10, 12);
        chk("t1_tlc", t_last_count, 3);
        chk("t1_frame_done", fd_cnt - fd0, 1);

        // 2: same frame, downstream ready one cycle in three
        rearm();
        tr_mode = 1;
        step(2);
        r0   = rdy_low;
        base = got.size();
        fd0  = fd_cnt;
        send_frame(8'h20, 3, 4);
        wait_idle("t2");
        check_frame("t2", base, 12, 8'h20, 12);
        chk("t2_ready_dropped", 32'(rdy_low > r0), 1);
        chk("t2_stall_stable", stab_err, 0);
        chk("t2_frame_done", fd_cnt - fd0, 1);
        tr_mode = 0;
        step(2);

        // 3: continuous, three 2x3 frames with junk beats in between
        rearm();
        continuous = 1'b1;
        line_count = 2;
        base = got.size();
        fd0  = fd_cnt;
        for (int f = 0; f < 3; f++) begin
            if (f == 2) continuous = 1'b0;
            send_frame(8'(8'h30 + 6 * f), 2, 3);
            if (f < 2) begin
                r0 = rdy_low;
                send(8'hEE, 1'b0, 1'b1);
                send(8'hEF, 1'b0, 1'b0);
                send(8'hE0, 1'b0, 1'b1);
                step(5);
                chk($sformatf("t3_ready_between_%0d", f), rdy_low - r0, 0);
            end
        end
        wait_idle("t3");
        check_frame("t3", base, 18, 8'h30, 6);
        chk("t3_frame_done", fd_cnt - fd0, 3);
        chk("t3_tlc", t_last_count, 2);

        // 4: abort after 5 of 12 beats
        rearm();
        line_count = 3;
        base = got.size();
        fd0  = fd_cnt;
        for (int i = 0; i < 5; i++)
            send(8'(8'h40 + i), (i == 0), (i == 3));
        enable = 1'b0;
        wait_idle("t4");
        check_frame("t4", base, 5, 8'h40, 0);
        chk("t4_aborted", aborted, 1);
        chk("t4_tlc", t_last_count, 1);
        chk("t4_frame_done", fd_cnt - fd0, 0);

        // 5: line_count 0 behaves as one line
        rearm();
        line_count = 0;
        base = got.size();
        fd0  = fd_cnt;
        send_frame(8'h50, 1, 7);
        wait_idle("t5");
        check_frame("t5", base, 7, 8'h50, 7);
        chk("t5_aborted_cleared", aborted, 0);
        chk("t5_tlc", t_last_count, 1);
        chk("t5_frame_done", fd_cnt - fd0, 1);

        // 6: reset with three beats buffered, then a clean frame
        rearm();
        line_count = 3;
        tr_level   = 1'b0;
        step(2);
        base = got.size();
        for (int i = 0; i < 3; i++)
            send(8'(8'hA0 + i), (i == 0), 1'b0);
        step(2);
        @(negedge clk);
        chk("t6_held_tvalid", bus.m_axis_tvalid, 1);
        chk("t6_held_tlc", t_last_count, 0);
        @(posedge clk);
        #1;
        video_reset = 1'b1;
        @(posedge clk);
        #1;
        video_reset = 1'b0;
        @(negedge clk);
        chk("t6_tvalid_after_reset", bus.m_axis_tvalid, 0);
        chk("t6_tlc_after_reset", t_last_count, 0);
        chk("t6_busy_after_reset", busy, 0);
        @(posedge clk);
        #1;
        tr_level = 1'b1;
        step(3);
        chk("t6_no_stale_beats", got.size() - base, 0);
        base = got.size();
        fd0  = fd_cnt;
        send_frame(8'h60, 3, 4);
        wait_idle("t6");
        check_frame("t6", base, 12, 8'h60, 12);
        chk("t6_tlc", t_last_count, 3);
        chk("t6_frame_done", fd_cnt - fd0, 1);
        chk("final_stall_stable", stab_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
